// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared CTI codes, master limit and round-robin search for wb_master_arb.
package wb_arb_pkg;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB = 3'b111;
  localparam int MAX_MASTERS = 8;
  // Unused high request bits are zero, so a mod-8 walk from ptr equals a mod-N walk.
  function automatic logic [2:0] next_rr(input logic [MAX_MASTERS-1:0] req, input logic [2:0] ptr);
    logic [2:0] w;
    w = ptr;
    for (int i = MAX_MASTERS - 1; i >= 0; i--)
      if (req[ptr + 3'(i)]) w = ptr + 3'(i);
    return w;
  endfunction
endpackage

// File: rtl/wb_arb_rr_pick.sv
// wb_arb_rr_pick: combinational picker, first requester at or after ptr (wrapping).
module wb_arb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0]         req,
  input  logic [$clog2(NUM_MASTERS)-1:0] ptr,
  output logic                           found,
  output logic [$clog2(NUM_MASTERS)-1:0] idx
);
  logic [2:0] win;
  always_comb begin
    win = next_rr(MAX_MASTERS'(req), 3'(ptr));
    found = |req;
    idx = win[$clog2(NUM_MASTERS)-1:0];
  end
endmodule

// File: rtl/wb_master_arb.sv
// wb_master_arb: Wishbone B4 multi-master arbiter, round-robin or fixed priority, burst ownership.
// Define WB_ARB_WATCHDOG_EN to build the watchdog that errors the owner of a stalled slave.
module wb_master_arb
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RR_EN = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NUM_MASTERS-1:0]        i_m_cyc,
  input  logic [NUM_MASTERS-1:0]        i_m_stb,
  input  logic [NUM_MASTERS-1:0]        i_m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] i_m_adr,
  input  logic [NUM_MASTERS*DATA_W-1:0] i_m_dat,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] i_m_sel,
  input  logic [NUM_MASTERS*3-1:0]      i_m_cti,
  output logic [NUM_MASTERS-1:0]        o_m_ack,
  output logic [NUM_MASTERS-1:0]        o_m_err,
  output logic [DATA_W-1:0]             o_m_dat,
  output logic                          o_wb_cyc,
  output logic                          o_wb_stb,
  output logic                          o_wb_we,
  output logic [ADDR_W-1:0]             o_wb_adr,
  output logic [DATA_W-1:0]             o_wb_dat,
  output logic [DATA_W/8-1:0]           o_wb_sel,
  output logic [2:0]                    o_wb_cti,
  input  logic                          i_wb_ack,
  input  logic [DATA_W-1:0]             i_wb_dat,
  output logic [NUM_MASTERS-1:0]        o_grant
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int SW = DATA_W / 8;

  logic          gnt_valid_q, gnt_valid_d;
  logic [IW-1:0] gnt_idx_q, gnt_idx_d, rr_ptr_q, rr_ptr_d, pick_idx;
  logic          pick_found, arb, stb_raw, wd_hit;
  logic [NUM_MASTERS-1:0] owner_oh;

  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_params
    $error("wb_master_arb: parameter out of range");
  end

  wb_arb_rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
    .req  (i_m_cyc),
    .ptr  (RR_EN != 0 ? rr_ptr_q : '0),
    .found(pick_found),
    .idx  (pick_idx)
  );

  // Re-arbitrate only when idle or when the owner lets go of cyc, so bursts stay intact.
  always_comb begin
    arb = !gnt_valid_q || !i_m_cyc[gnt_idx_q];
    gnt_valid_d = arb ? pick_found : gnt_valid_q;
    gnt_idx_d = (arb && pick_found) ? pick_idx : gnt_idx_q;
    rr_ptr_d = !(arb && pick_found) ? rr_ptr_q :
               (pick_idx == IW'(NUM_MASTERS - 1)) ? '0 : pick_idx + IW'(1);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      gnt_valid_q <= 1'b0;
      gnt_idx_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q <= gnt_idx_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    owner_oh = gnt_valid_q ? NUM_MASTERS'(1) << gnt_idx_q : '0;
    stb_raw = gnt_valid_q && i_m_stb[gnt_idx_q];
    o_wb_cyc = gnt_valid_q && i_m_cyc[gnt_idx_q];
    o_wb_stb = stb_raw && !wd_hit;
    o_wb_we = gnt_valid_q && i_m_we[gnt_idx_q];
    o_wb_adr = gnt_valid_q ? i_m_adr[gnt_idx_q*ADDR_W +: ADDR_W] : '0;
    o_wb_dat = gnt_valid_q ? i_m_dat[gnt_idx_q*DATA_W +: DATA_W] : '0;
    o_wb_sel = gnt_valid_q ? i_m_sel[gnt_idx_q*SW +: SW] : '0;
    o_wb_cti = gnt_valid_q ? i_m_cti[gnt_idx_q*3 +: 3] : '0;
    o_m_ack = i_wb_ack ? owner_oh : '0;
    o_m_err = wd_hit ? owner_oh : '0;
    o_grant = owner_oh;
    o_m_dat = i_wb_dat;
  end

`ifdef WB_ARB_WATCHDOG_EN
  logic [15:0] wd_cnt_q, wd_cnt_d;
  always_comb begin
    wd_hit = gnt_valid_q && wd_cnt_q == 16'(TIMEOUT);
    wd_cnt_d = (wd_hit || arb || !stb_raw || i_wb_ack) ? '0 : wd_cnt_q + 16'd1;
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) wd_cnt_q <= '0;
    else wd_cnt_q <= wd_cnt_d;
  end
`else
  assign wd_hit = 1'b0;
`endif
endmodule

// File: tb/tb_wb_master_arb.sv
// tb_wb_master_arb: directed plan plus random traffic, round-robin and fixed-priority instances.
module tb_wb_master_arb;
  import wb_arb_pkg::*;
  localparam int N = 3, AW = 32, DW = 32, SW = DW / 8, TO = 8;
`ifdef WB_ARB_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] cyc = '0, stb = '0, we = '0;
  logic [N*AW-1:0] adr = '0;
  logic [N*DW-1:0] dat = '0;
  logic [N*SW-1:0] sel = '0;
  logic [N*3-1:0] cti = '0;
  logic wb_ack = 1'b0;
  logic [DW-1:0] wb_dat = '0;
  logic [N-1:0] og[2], oack[2], oerr[2];
  logic [DW-1:0] omdat[2], odat[2];
  logic ocyc[2], ostb[2], owe[2];
  logic [AW-1:0] oadr[2];
  logic [SW-1:0] osel[2];
  logic [2:0] octi[2];
  int errs = 0, checks = 0;
  int mv[2], mo[2], mp[2], mw[2];
  logic [N-1:0] got;
  int owners[$];
  int t, err_at, b;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_master_arb #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .RR_EN(g == 0 ? 1 : 0), .TIMEOUT(TO)) u_dut (
      .i_clk(clk), .i_reset(rst),
      .i_m_cyc(cyc), .i_m_stb(stb), .i_m_we(we), .i_m_adr(adr), .i_m_dat(dat), .i_m_sel(sel), .i_m_cti(cti),
      .o_m_ack(oack[g]), .o_m_err(oerr[g]), .o_m_dat(omdat[g]),
      .o_wb_cyc(ocyc[g]), .o_wb_stb(ostb[g]), .o_wb_we(owe[g]), .o_wb_adr(oadr[g]), .o_wb_dat(odat[g]),
      .o_wb_sel(osel[g]), .o_wb_cti(octi[g]), .i_wb_ack(wb_ack), .i_wb_dat(wb_dat), .o_grant(og[g])
    );
  end

  task automatic chk(input string tag, input logic [127:0] got_v, input logic [127:0] exp_v);
    checks++;
    assert (got_v === exp_v) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  // Reference: owner held while its cyc stays high; otherwise first requester from the search start.
  task automatic model_step();
    for (int r = 0; r < 2; r++) begin
      logic hit, arbd, raw, found;
      int st, j;
      if (rst) begin mv[r] = 0; mo[r] = 0; mp[r] = 0; mw[r] = 0; end
      hit = WD_ON && mv[r] != 0 && mw[r] == TO;
      chk($sformatf("grant[%0d]", r), og[r], mv[r] != 0 ? N'(1) << mo[r] : '0);
      chk($sformatf("cyc[%0d]", r), ocyc[r], mv[r] != 0 ? cyc[mo[r]] : 1'b0);
      chk($sformatf("stb[%0d]", r), ostb[r], mv[r] != 0 ? stb[mo[r]] && !hit : 1'b0);
      chk($sformatf("we[%0d]", r), owe[r], mv[r] != 0 ? we[mo[r]] : 1'b0);
      chk($sformatf("adr[%0d]", r), oadr[r], mv[r] != 0 ? adr[mo[r]*AW +: AW] : '0);
      chk($sformatf("wdat[%0d]", r), odat[r], mv[r] != 0 ? dat[mo[r]*DW +: DW] : '0);
      chk($sformatf("sel[%0d]", r), osel[r], mv[r] != 0 ? sel[mo[r]*SW +: SW] : '0);
      chk($sformatf("cti[%0d]", r), octi[r], mv[r] != 0 ? cti[mo[r]*3 +: 3] : '0);
      chk($sformatf("ack[%0d]", r), oack[r], (mv[r] != 0 && wb_ack) ? N'(1) << mo[r] : '0);
      chk($sformatf("err[%0d]", r), oerr[r], hit ? N'(1) << mo[r] : '0);
      chk($sformatf("mdat[%0d]", r), omdat[r], wb_dat);
      if (!rst) begin
        arbd = mv[r] == 0 || !cyc[mo[r]];
        raw = mv[r] != 0 && stb[mo[r]];
        mw[r] = (hit || arbd || !raw || wb_ack) ? 0 : mw[r] + 1;
        if (arbd) begin
          st = r == 0 ? mp[r] : 0;
          found = 1'b0;
          for (int k = 0; k < N; k++) begin
            j = (st + k) % N;
            if (!found && cyc[j]) begin found = 1'b1; mo[r] = j; mp[r] = (j + 1) % N; end
          end
          mv[r] = found ? 1 : 0;
        end
      end
    end
  endtask

  task automatic sample(); @(negedge clk); model_step(); endtask
  task automatic adv(); @(posedge clk); #1; endtask
  task automatic set_m(input int k, input logic c, input logic s, input logic [2:0] ct);
    cyc[k] = c; stb[k] = s; cti[k*3 +: 3] = ct;
  endtask
  task automatic idle();
    cyc = '0; stb = '0; cti = '0; wb_ack = 1'b0;
    sample(); adv(); sample(); adv();
  endtask

  initial begin
    sample();
    chk("rst_cyc", ocyc[0], 1'b0);
    chk("rst_stb", ostb[0], 1'b0);
    chk("rst_grant", og[0], 3'b000);
    chk("rst_ack", oack[0], 3'b000);
    adv();
    rst = 1'b0;
    // single read by master 0
    set_m(0, 1'b1, 1'b1, CTI_CLASSIC);
    adr[0 +: AW] = 32'h0340_0000;
    sample(); chk("rd_lat0", ocyc[0], 1'b0); adv();
    sample(); chk("rd_cyc", ocyc[0], 1'b1); chk("rd_adr", oadr[0], 32'h0340_0000); adv();
    sample(); chk("rd_wait", oack[0], 3'b000); adv();
    wb_ack = 1'b1; wb_dat = 32'h1234_5678;
    sample(); chk("rd_ack", oack[0], 3'b001); chk("rd_dat", omdat[0], 32'h1234_5678); adv();
    wb_ack = 1'b0; set_m(0, 1'b0, 1'b0, CTI_CLASSIC);
    sample(); chk("rd_ack_once", oack[0], 3'b000); adv();
    // round-robin fairness with single-beat cycles
    got = '0;
    for (int c = 0; c < 40 && owners.size() < 6; c++) begin
      for (int k = 0; k < 2; k++) begin cyc[k] = !got[k]; stb[k] = !got[k]; end
      #1 wb_ack = ostb[0];
      sample();
      got = oack[0];
      if (oack[0] != '0) owners.push_back(oack[0] == 3'b001 ? 0 : oack[0] == 3'b010 ? 1 : 9);
      adv();
    end
    chk("rr_count", owners.size(), 6);
    for (int i = 1; i < owners.size(); i++) begin
      chk($sformatf("rr_alt%0d", i), owners[i] != owners[i-1], 1'b1);
      chk($sformatf("rr_idx%0d", i), owners[i] < 2, 1'b1);
    end
    // burst hold by master 1 with an stb gap
    idle();
    set_m(1, 1'b1, 1'b1, CTI_INCR);
    sample(); chk("bh_idle", og[0], 3'b000); adv();
    b = 0;
    for (int i = 0; i < 5; i++) begin
      cyc[0] = 1'b1; stb[0] = 1'b1;
      set_m(1, 1'b1, i != 2, b == 3 ? CTI_EOB : CTI_INCR);
      wb_ack = i != 2;
      sample();
      chk("bh_grant", og[0], 3'b010);
      chk("bh_cti", octi[0], b == 3 ? CTI_EOB : CTI_INCR);
      if (i != 2) b++;
      adv();
    end
    set_m(1, 1'b0, 1'b0, CTI_CLASSIC); wb_ack = 1'b0;
    sample(); chk("bh_drop", og[0], 3'b010); chk("bh_dropcyc", ocyc[0], 1'b0); adv();
    sample(); chk("bh_handover", og[0], 3'b001); chk("bh_m0cyc", ocyc[0], 1'b1); adv();
    // fixed priority instance: masters 0 and 2
    idle();
    cyc[0] = 1'b1; cyc[2] = 1'b1;
    sample(); adv();
    sample(); chk("fp_first", og[1], 3'b001); adv();
    cyc[0] = 1'b0;
    sample(); adv();
    cyc[0] = 1'b1;
    sample(); chk("fp_m2", og[1], 3'b100); adv();
    cyc[2] = 1'b0;
    sample(); chk("fp_hold", og[1], 3'b100); adv();
    sample(); chk("fp_back", og[1], 3'b001); adv();
    // stalled slave
    idle();
    set_m(0, 1'b1, 1'b1, CTI_CLASSIC);
    t = -1; err_at = -1;
    for (int c = 0; c < 24; c++) begin
      sample();
      if (t >= 0) t++;
      else if (ostb[0]) t = 0;
      if (oerr[0][0] && err_at < 0) begin err_at = t; chk("wd_stb", ostb[0], 1'b0); end
      adv();
    end
    chk("wd_err_at", err_at, WD_ON ? 8 : -1);
    // asynchronous reset mid-burst
    idle();
    set_m(1, 1'b1, 1'b1, CTI_INCR);
    sample(); adv();
    sample(); chk("rs_pre", og[0], 3'b010);
    #2 rst = 1'b1;
    #1;
    chk("rs_cyc", ocyc[0], 1'b0);
    chk("rs_stb", ostb[0], 1'b0);
    chk("rs_grant", og[0], 3'b000);
    chk("rs_grant_fp", og[1], 3'b000);
    for (int r = 0; r < 2; r++) begin mv[r] = 0; mp[r] = 0; mw[r] = 0; end
    set_m(2, 1'b1, 1'b1, CTI_CLASSIC);
    adv(); sample(); adv();
    rst = 1'b0;
    sample(); chk("rs_rel", og[0], 3'b000); adv();
    sample(); chk("rs_first", og[0], 3'b010); chk("rs_first_fp", og[1], 3'b010); adv();
    // random traffic against the reference model
    idle();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        cyc[k] = cyc[k] ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 7) == 0) stb[k] = !stb[k];
        we[k] = 1'($urandom);
        adr[k*AW +: AW] = $urandom;
        dat[k*DW +: DW] = $urandom;
        sel[k*SW +: SW] = SW'($urandom);
        cti[k*3 +: 3] = 3'($urandom);
      end
      wb_ack = (c % 64 < 32) ? ($urandom_range(0, 2) == 0) : 1'b0;
      wb_dat = $urandom;
      sample(); adv();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
